wb_port_arbiter: RTL and testbench

- Sits between the back end of the RV32I core and the register-file write port (AD3/WE3/WD3), and is the only driver of that port.
- It merges two write sources: the in-order pipeline writeback, and a long-latency unit (load/store or mul/div) that returns results out of band.
- The long-latency unit uses a valid/ready handshake and is buffered in a small FIFO.
- Outputs are registered. The block also exports a pending-destination mask so the hazard unit can stall readers of registers that still have a write in flight.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 62 ++++++
 rtl/wb_port_arbiter.sv | 89 ++++++++
 tb/tb_wb_port_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_pkg;

  localparam int WB_DATA_WIDTH    = 32;
  localparam int WB_ADDRESS_WIDTH = 5;

  localparam logic [WB_ADDRESS_WIDTH-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_ADDRESS_WIDTH-1:0] rd;
    logic [WB_DATA_WIDTH-1:0]    wd;
  } wb_req_t;

  typedef struct packed {
    wb_req_t req;
    logic    kill;
  } fifo_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO for long-latency writebacks, with per-entry kill-by-destination
// and a decoded mask of live destinations.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             push,
  input  fifo_entry_t                      push_entry,
  input  logic                             pop,
  input  logic                             match_en,
  input  logic [WB_ADDRESS_WIDTH-1:0]      match_rd,
  output fifo_entry_t                      head,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(DEPTH):0]           count,
  output logic [2**WB_ADDRESS_WIDTH-1:0]   live_mask
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t   mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == (PW+1)'(DEPTH));
  assign head  = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // A younger pipeline write to the same register makes the buffered value stale.
      for (int i = 0; i < DEPTH; i++) begin
        if (match_en && mem[i].req.rd == match_rd) mem[i].kill <= 1'b1;
      end
      if (push) begin
        mem[wr_ptr[PW-1:0]] <= push_entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    logic [PW-1:0] off;
    live_mask = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr[PW-1:0];
      if (({1'b0, off} < count) && !mem[i].kill) live_mask[mem[i].req.rd] = 1'b1;
    end
    live_mask[0] = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Sole driver of the register-file write port: merges in-order pipeline
// writeback with buffered long-latency results, pipeline first.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            pipe_we,
  input  logic [ADDRESS_WIDTH-1:0]        pipe_rd,
  input  logic [DATA_WIDTH-1:0]           pipe_wd,
  input  logic                            lsu_valid,
  output logic                            lsu_ready,
  input  logic [ADDRESS_WIDTH-1:0]        lsu_rd,
  input  logic [DATA_WIDTH-1:0]           lsu_wd,
  output logic [ADDRESS_WIDTH-1:0]        AD3,
  output logic                            WE3,
  output logic [DATA_WIDTH-1:0]           WD3,
  output logic [2**ADDRESS_WIDTH-1:0]     pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  fifo_entry_t head;
  fifo_entry_t push_entry;
  logic        empty;
  logic        full;
  logic        handshake;
  logic        pipe_hit;
  logic        pop;
  logic        bypass;
  logic        push;

  assign lsu_ready = !full;
  assign handshake = lsu_valid && lsu_ready;
  assign pipe_hit  = pipe_we && (pipe_rd != REG_ZERO);
  assign pop       = !pipe_hit && !empty;
  assign bypass    = !pipe_hit && empty && handshake && (lsu_rd != REG_ZERO);
  assign push      = handshake && !bypass;

  // x0 destinations and same-cycle pipeline collisions enter the buffer already dead.
  assign push_entry.req.rd = lsu_rd;
  assign push_entry.req.wd = lsu_wd;
  assign push_entry.kill   = (lsu_rd == REG_ZERO) || (pipe_we && pipe_rd == lsu_rd);

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .match_en   (pipe_hit),
    .match_rd   (pipe_rd),
    .head       (head),
    .empty      (empty),
    .full       (full),
    .count      (fifo_count),
    .live_mask  (pending_mask)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE3 <= 1'b0;
      AD3 <= '0;
      WD3 <= '0;
    end else if (pipe_hit) begin
      WE3 <= 1'b1;
      AD3 <= pipe_rd;
      WD3 <= pipe_wd;
    end else if (pop) begin
      WE3 <= !head.kill;
      if (!head.kill) begin
        AD3 <= head.req.rd;
        WD3 <= head.req.wd;
      end
    end else if (bypass) begin
      WE3 <= 1'b1;
      AD3 <= lsu_rd;
      WD3 <= lsu_wd;
    end else begin
      WE3 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and randomized checks of wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_wd;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wd;
  logic [4:0]  AD3;
  logic        WE3;
  logic [31:0] WD3;
  logic [31:0] pending_mask;
  logic [1:0]  fifo_count;

  wb_port_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pipe_we      (pipe_we),
    .pipe_rd      (pipe_rd),
    .pipe_wd      (pipe_wd),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_wd       (lsu_wd),
    .AD3          (AD3),
    .WE3          (WE3),
    .WD3          (WD3),
    .pending_mask (pending_mask),
    .fifo_count   (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        kill;
  } ent_t;

  ent_t        q[$];
  logic        exp_we;
  logic [4:0]  exp_ad;
  logic [31:0] exp_wd;
  logic [31:0] dut_rf [32];
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic pw, input logic [4:0] prd, input logic [31:0] pwd,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] lwd);
    pipe_we = pw; pipe_rd = prd; pipe_wd = pwd;
    lsu_valid = lv; lsu_rd = lrd; lsu_wd = lwd;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (q[i]) if (!q[i].kill && q[i].rd != 0) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  // One clock: check occupancy-side outputs, advance the model, check the write port.
  task automatic step();
    logic hs, ph, byp;
    ent_t e;
    #1;
    chk("lsu_ready", lsu_ready, q.size() != DEPTH);
    chk("pending_mask", pending_mask, model_mask());
    chk("fifo_count", fifo_count, q.size());
    hs  = lsu_valid && (q.size() != DEPTH);
    ph  = pipe_we && pipe_rd != 0;
    byp = 1'b0;
    exp_we = 1'b0;
    if (ph) begin
      exp_we = 1'b1; exp_ad = pipe_rd; exp_wd = pipe_wd;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      if (!e.kill) begin exp_we = 1'b1; exp_ad = e.rd; exp_wd = e.wd; end
    end else if (hs && lsu_rd != 0) begin
      byp = 1'b1; exp_we = 1'b1; exp_ad = lsu_rd; exp_wd = lsu_wd;
    end
    if (ph) foreach (q[i]) if (q[i].rd == pipe_rd) q[i].kill = 1'b1;
    if (hs && !byp) begin
      e.rd = lsu_rd; e.wd = lsu_wd;
      e.kill = (lsu_rd == 0) || (pipe_we && pipe_rd == lsu_rd);
      q.push_back(e);
    end
    @(posedge clk); #1;
    chk("WE3", WE3, exp_we);
    if (exp_we) begin
      chk("AD3", AD3, exp_ad);
      chk("WD3", WD3, exp_wd);
    end
    if (WE3 === 1'b1) dut_rf[AD3] = WD3;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_WE3"}, WE3, 0);
    chk({tag, "_AD3"}, AD3, 0);
    chk({tag, "_WD3"}, WD3, 0);
    chk({tag, "_ready"}, lsu_ready, 1);
    chk({tag, "_mask"}, pending_mask, 0);
    chk({tag, "_count"}, fifo_count, 0);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    reset_checks("rst_async");
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst_hold");
    q.delete();
    exp_we = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    foreach (dut_rf[i]) dut_rf[i] = '0;
    @(posedge clk); #1;
    do_reset();
    step();

    // Bypass into an empty buffer.
    set_in(0, 0, 0, 1, 10, 32'hDEADBEEF);
    step();
    chk("bypass_we", WE3, 1); chk("bypass_ad", AD3, 10);
    chk("bypass_wd", WD3, 32'hDEADBEEF); chk("bypass_count", fifo_count, 0);

    // Pipeline priority with buffered lsu result.
    set_in(1, 5, 1, 1, 6, 2);
    step();
    chk("prio_ad", AD3, 5); chk("prio_wd", WD3, 1);
    chk("prio_pend6", pending_mask[6], 1); chk("prio_count", fifo_count, 1);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("drain_ad", AD3, 6); chk("drain_wd", WD3, 2); chk("drain_mask", pending_mask, 0);

    // Fill the buffer, observe back-pressure, drain in order.
    set_in(1, 1, 32'h101, 1, 7, 32'h70); step();
    set_in(1, 2, 32'h102, 1, 8, 32'h80); step();
    chk("full_count", fifo_count, 2); chk("full_ready", lsu_ready, 0);
    set_in(1, 3, 32'h103, 1, 9, 32'h90); step();
    chk("held_count", fifo_count, 2);
    set_in(0, 0, 0, 1, 9, 32'h90); step();
    chk("order_x7", AD3, 7);
    step();
    chk("order_x8", AD3, 8);
    set_in(0, 0, 0, 0, 0, 0); step();
    chk("order_x9", AD3, 9); chk("order_ready", lsu_ready, 1);

    // WAW squash of a buffered entry.
    set_in(1, 3, 32'h33, 1, 9, 32'h11); step();
    chk("waw_pend9", pending_mask[9], 1);
    set_in(1, 9, 32'h22, 0, 0, 0); step();
    chk("waw_wd", WD3, 32'h22); chk("waw_pend9_clr", pending_mask[9], 0);
    set_in(0, 0, 0, 0, 0, 0); step();
    chk("waw_pop_we", WE3, 0); chk("waw_x9", dut_rf[9], 32'h22);

    // x0 destinations.
    set_in(0, 0, 0, 1, 0, 32'h55); step();
    chk("x0_count", fifo_count, 1); chk("x0_mask", pending_mask, 0);
    set_in(0, 0, 0, 0, 0, 0); step();
    chk("x0_pop_we", WE3, 0);
    set_in(1, 4, 32'h44, 1, 12, 32'h33); step();
    set_in(1, 0, 32'hBAD, 0, 0, 0); step();
    chk("pipe_x0_pop_ad", AD3, 12); chk("pipe_x0_count", fifo_count, 0);

    // Reset while the buffer is full.
    set_in(1, 1, 32'h1, 1, 13, 32'h13); step();
    set_in(1, 2, 32'h2, 1, 14, 32'h14); step();
    chk("pre_rst_count", fifo_count, 2);
    do_reset();
    set_in(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_we", WE3, 0);
    end

    // Randomized traffic with small register indices to force collisions.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
